// File: rtl/demux4_router.sv
// demux4_router: 1-to-4 routing demultiplexer with registered outputs.
// Each accepted input word is delivered to exactly one of four output channels. Every channel
// has its own one-entry holding register and a valid/ready handshake to its consumer.
//
// Ports:
//   clock      - system clock, rising-edge active
//   reset      - asynchronous active-low reset
//   in_data    - word to route
//   in_sel     - destination channel (0..3)
//   in_valid   - in_data/in_sel valid this cycle
//   in_ready   - selected channel can take the word this cycle
//   out_data   - channel k data at [k*WIDTH +: WIDTH]
//   out_valid  - bit k: channel k holds a word
//   out_ready  - bit k: consumer of channel k takes the word this cycle
//   xfer_count - accepted input words, modulo 256
module demux4_router #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [4*WIDTH-1:0] out_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [7:0]         xfer_count
);

  logic [WIDTH-1:0] r_hold [4];
  logic [3:0]       r_valid;
  logic [7:0]       r_count;

  logic             w_accept;
  logic [3:0]       w_acc_onehot;
  logic [3:0]       w_drain;
  logic [3:0]       w_valid_d;

  always_comb begin
    // Only the selected channel can stall the input.
    in_ready     = ~r_valid[in_sel] | out_ready[in_sel];
    w_accept     = in_valid & in_ready;
    w_acc_onehot = w_accept ? (4'b0001 << in_sel) : 4'b0000;
    w_drain      = r_valid & out_ready;
    // An accept into a draining channel keeps it full: accept wins over drain.
    w_valid_d    = (r_valid & ~w_drain) | w_acc_onehot;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= 4'b0000;
      r_count <= 8'd0;
      for (int k = 0; k < 4; k++) begin
        r_hold[k] <= '0;
      end
    end else begin
      r_valid <= w_valid_d;
      for (int k = 0; k < 4; k++) begin
        if (w_acc_onehot[k]) begin
          r_hold[k] <= in_data;
        end
      end
      if (w_accept) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      out_data[k*WIDTH +: WIDTH] = r_hold[k];
    end
  end

  assign out_valid  = r_valid;
  assign xfer_count = r_count;

endmodule
